reg_wb_writer: RTL and testbench

// Write side of the register-file port: merges single-cycle ALU/link results and

---
 rtl/reg_wb_if.sv | 34 +++
 rtl/reg_wb_writer.sv | 137 +++++++++++++
 tb/tb_reg_wb_writer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/reg_wb_if.sv
// Bundle of the register-file write-back port: ALU/link request, MDU result handshake,
// and the registered write port plus decode-side busy/stall indications.
interface reg_wb_if #(
  parameter int DATA_W = 32
);
  logic              alu_valid_i;
  logic [4:0]        alu_addr_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              link_i;
  logic [31:0]       pc_4_i;
  logic              mdu_valid_i;
  logic              mdu_ready_o;
  logic [4:0]        mdu_addr_i;
  logic [DATA_W-1:0] mdu_data_i;
  logic              RegWrite_o;
  logic [4:0]        RDaddr_o;
  logic [DATA_W-1:0] RDdata_o;
  logic [31:0]       busy_o;
  logic              stall_o;

  // MDU handshake: a result transfers in any cycle where mdu_valid_i && mdu_ready_o;
  // the offer may be held across cycles and carries no other ordering obligation.
  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i, link_i, pc_4_i,
    output mdu_valid_i, mdu_addr_i, mdu_data_i,
    input  mdu_ready_o, RegWrite_o, RDaddr_o, RDdata_o, busy_o, stall_o
  );

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i, link_i, pc_4_i,
    input  mdu_valid_i, mdu_addr_i, mdu_data_i,
    output mdu_ready_o, RegWrite_o, RDaddr_o, RDdata_o, busy_o, stall_o
  );
endinterface

// File: rtl/reg_wb_writer.sv
// Merges ALU/link results and queued MDU results onto one register-file write port.
// Optional WB_PERF_CNT_EN adds stall-cycle and squashed-entry counters.
module reg_wb_writer #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  parameter int DATA_W     = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  reg_wb_if.slave     wb
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] squash_cnt_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]        addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d, squash_vec;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rw_q, rw_d, stall_q, stall_d;
  logic [4:0]        rd_addr_q, rd_addr_d, alu_addr;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, alu_data;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              empty, full, push, pop;
  logic [31:0]       busy;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign push   = wb.mdu_valid_i && !full;
  assign pop    = !wb.alu_valid_i && !empty;

  always_comb begin
    alu_addr   = wb.link_i ? 5'd31 : wb.alu_addr_i;
    alu_data   = wb.link_i ? DATA_W'(wb.pc_4_i) : wb.alu_data_i;
    squash_vec = '0;
    // Older queued results to the ALU's target are dead; writes to $0 never count.
    for (int i = 0; i < DEPTH; i++) begin
      squash_vec[i] = wb.alu_valid_i && (alu_addr != 5'd0) && vld_q[i] &&
                      (addr_q[i] == alu_addr);
    end
    vld_d = vld_q & ~squash_vec;
    if (pop)  vld_d[rd_idx] = 1'b0;
    if (push) vld_d[wr_idx] = 1'b1;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    rw_d      = 1'b0;
    rd_addr_d = '0;
    rd_data_d = '0;
    if (wb.alu_valid_i) begin
      rw_d      = (alu_addr != 5'd0);
      rd_addr_d = alu_addr;
      rd_data_d = alu_data;
    end else if (pop) begin
      rw_d      = vld_q[rd_idx] && (addr_q[rd_idx] != 5'd0);
      rd_addr_d = addr_q[rd_idx];
      rd_data_d = data_q[rd_idx];
    end

    // Non-empty without a pop means the ALU took the port this cycle.
    if (empty || pop)                    cnt_d = '0;
    else if (cnt_q != CW'(STARVE_MAX))   cnt_d = cnt_q + CW'(1);
    else                                 cnt_d = cnt_q;
    stall_d = (cnt_q == CW'(STARVE_MAX)) && !pop;

    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) busy[addr_q[i]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      vld_q     <= '0;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      vld_q     <= vld_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      stall_q   <= stall_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_idx] <= wb.mdu_addr_i;
      data_q[wr_idx] <= wb.mdu_data_i;
    end
  end

  assign wb.mdu_ready_o = !full;
  assign wb.RegWrite_o  = rw_q;
  assign wb.RDaddr_o    = rd_addr_q;
  assign wb.RDdata_o    = rd_data_q;
  assign wb.busy_o      = busy;
  assign wb.stall_o     = stall_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0] stall_cnt_q, squash_cnt_q, squash_n;

  always_comb begin
    squash_n = '0;
    for (int i = 0; i < DEPTH; i++) squash_n = squash_n + 32'(squash_vec[i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_q + 32'(stall_q);
      squash_cnt_q <= squash_cnt_q + squash_n;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign squash_cnt_o = squash_cnt_q;
`endif
endmodule

// File: tb/tb_reg_wb_writer.sv
// Directed vector bench for reg_wb_writer: each row is one cycle of inputs plus the
// registered/queued state expected right after that clock edge.
module tb_reg_wb_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_wb_if #(.DATA_W(32)) wb ();
`ifdef WB_PERF_CNT_EN
  logic [31:0] stall_cnt, squash_cnt;
`endif

  reg_wb_writer #(.DEPTH(4), .STARVE_MAX(8), .DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wb)
`ifdef WB_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt),
    .squash_cnt_o (squash_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic        lk;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic [31:0] pc;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [31:0] eb;
    logic        es;
    logic        er;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   row   = 0;

  task automatic add(input logic r, input logic av, input logic lk, input logic [4:0] aa,
                     input logic [31:0] ad, input logic [31:0] pc, input logic mv,
                     input logic [4:0] ma, input logic [31:0] md, input logic ew,
                     input logic [4:0] ea, input logic [31:0] ed, input logic [31:0] eb,
                     input logic es, input logic er);
    vec_t v;
    v.rst = r;  v.av = av; v.lk = lk; v.aa = aa; v.ad = ad; v.pc = pc;
    v.mv = mv;  v.ma = ma; v.md = md; v.ew = ew; v.ea = ea; v.ed = ed;
    v.eb = eb;  v.es = es; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst            = v.rst;
    wb.alu_valid_i = v.av;
    wb.link_i      = v.lk;
    wb.alu_addr_i  = v.aa;
    wb.alu_data_i  = v.ad;
    wb.pc_4_i      = v.pc;
    wb.mdu_valid_i = v.mv;
    wb.mdu_addr_i  = v.ma;
    wb.mdu_data_i  = v.md;
    @(posedge clk);
    #1;
    chk("regwrite", 32'(wb.RegWrite_o), 32'(v.ew));
    if (v.ew || v.rst) begin
      chk("rdaddr", 32'(wb.RDaddr_o), 32'(v.ea));
      chk("rddata", wb.RDdata_o, v.ed);
    end
    chk("busy", wb.busy_o, v.eb);
    chk("stall", 32'(wb.stall_o), 32'(v.es));
    chk("mdu_ready", 32'(wb.mdu_ready_o), 32'(v.er));
    row++;
  endtask

  initial begin
    vec_t v;
    wb.alu_valid_i = 1'b0; wb.link_i = 1'b0; wb.alu_addr_i = '0; wb.alu_data_i = '0;
    wb.pc_4_i = '0; wb.mdu_valid_i = 1'b0; wb.mdu_addr_i = '0; wb.mdu_data_i = '0;

    // Power-on reset: two cycles, then the reset state itself.
    add(1, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,1);
    add(1, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,1);
    // Plain ALU write, link, write to $0, idle.
    add(0, 1,0,5,32'h1234,0,      0,0,0, 1,5,32'h1234, 0,0,1);
    add(0, 1,1,7,32'h999,32'h40,  0,0,0, 1,31,32'h40,  0,0,1);
    add(0, 1,0,0,32'h55,0,        0,0,0, 0,0,0,        0,0,1);
    add(0, 0,0,0,0,0,             0,0,0, 0,0,0,        0,0,1);
    // Fill the FIFO with $8..$11 behind continuous ALU writes to $2.
    add(0, 1,0,2,32'h100,0, 1,8, 32'h800, 1,2,32'h100, 32'h100,0,1);
    add(0, 1,0,2,32'h101,0, 1,9, 32'h801, 1,2,32'h101, 32'h300,0,1);
    add(0, 1,0,2,32'h102,0, 1,10,32'h802, 1,2,32'h102, 32'h700,0,1);
    add(0, 1,0,2,32'h103,0, 1,11,32'h803, 1,2,32'h103, 32'hF00,0,0);
    // Full: $13 offered but refused; starvation builds to stall.
    for (int i = 0; i < 5; i++)
      add(0, 1,0,2,32'h104+i,0, 1,13,32'hDEAD, 1,2,32'h104+i, 32'hF00,0,0);
    add(0, 1,0,2,32'h109,0, 1,13,32'hDEAD, 1,2,32'h109, 32'hF00,1,0);
    add(0, 1,0,2,32'h10A,0, 0,0,0,         1,2,32'h10A, 32'hF00,1,0);
    // ALU idle: drain in order, stall drops with the first pop.
    add(0, 0,0,0,0,0, 0,0,0, 1,8, 32'h800, 32'hE00,0,1);
    add(0, 0,0,0,0,0, 0,0,0, 1,9, 32'h801, 32'hC00,0,1);
    add(0, 0,0,0,0,0, 0,0,0, 1,10,32'h802, 32'h800,0,1);
    add(0, 0,0,0,0,0, 0,0,0, 1,11,32'h803, 32'h000,0,1);
    add(0, 0,0,0,0,0, 0,0,0, 0,0,0,        32'h000,0,1);
    // WAW squash: queued $9=AA overwritten by ALU $9=BB, squashed entry pops silently.
    add(0, 0,0,0,0,0,        1,9,32'hAA, 0,0,0,         32'h200,0,1);
    add(0, 1,0,9,32'hBB,0,   0,0,0,      1,9,32'hBB,    32'h0,0,1);
    add(0, 0,0,0,0,0,        0,0,0,      0,0,0,         32'h0,0,1);
    add(0, 0,0,0,0,0,        0,0,0,      0,0,0,         32'h0,0,1);
    // Push to $12 in the same cycle as an ALU write to $12 survives.
    add(0, 1,0,12,32'hDD,0,  1,12,32'hCC, 1,12,32'hDD,  32'h1000,0,1);
    add(0, 0,0,0,0,0,        0,0,0,       1,12,32'hCC,  32'h0,0,1);
    // Push and pop in the same cycle; MDU result to $0 pops without a write.
    add(0, 0,0,0,0,0,        1,3,32'h33, 0,0,0,         32'h8,0,1);
    add(0, 0,0,0,0,0,        1,4,32'h44, 1,3,32'h33,    32'h10,0,1);
    add(0, 0,0,0,0,0,        1,0,32'h77, 1,4,32'h44,    32'h0,0,1);
    add(0, 0,0,0,0,0,        0,0,0,      0,0,0,         32'h0,0,1);

    foreach (vecs[i]) apply(vecs[i]);

`ifdef WB_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 32'd2);
    chk("squash_cnt", squash_cnt, 32'd1);
`endif

    // Reset with three results queued: everything discarded, nothing written later.
    for (int i = 0; i < 3; i++) begin
      v = '{0, 1,0,5'd2,32'h200+i,0, 1,5'(20+i),32'h2000+i, 1,5'd2,32'h200+i,
            (32'h1 << (21 + i)) - 32'h100000, 0,1};
      apply(v);
    end
    v = '{1, 1,0,5'd5,32'h5,0, 1,5'd23,32'h2003, 0,5'd0,32'h0, 32'h0,0,1};
    apply(v);
`ifdef WB_PERF_CNT_EN
    chk("stall_cnt_rst", stall_cnt, 32'd0);
    chk("squash_cnt_rst", squash_cnt, 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      v = '{0, 0,0,5'd0,32'h0,0, 0,5'd0,32'h0, 0,5'd0,32'h0, 32'h0,0,1};
      apply(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
